button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
Shares one downstream event consumer among `width` edge-detected button/switch pulse sources. The block sits between the edge_detector outputs and a single consumer such as a tone/sequencer FSM.
- Each incoming single-cycle pulse is latched as a pending request.
- Pending requests are granted round-robin over a valid/ready handshake.
- After every accepted event, the block enforces a programmable hold-off gap so the consumer is paced.
- Lost events (overruns) are flagged per source.

Parameters:
- width, 4, number of pulse sources; legal range 2..16.
- GAP, 10, idle cycles inserted after each accepted event; 0 is legal.
- ID_W, $clog2(width), width of event_id; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- edge_pulse  input  width  one-cycle pulses from edge_detector, one bit per source.
- event_valid  output  1  an event is offered to the consumer.
- event_ready  input  1  consumer accepts the offered event.
- event_id  output  ID_W  index of the offered source; stable while event_valid=1.
- overrun  output  width  sticky flag: a pulse on that source was lost.
- overrun_clear  input  1  clears all overrun bits.
- busy  output  1  high when state!=IDLE or any pending bit is set.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, including mid-handshake):
  - event_valid=0, event_id=0, overrun=0, busy=0.
  - pending=0, rr_ptr=0, gap counter=0, state=IDLE.
- Pending latch:
  - edge_pulse[i]=1 at edge N sets pending[i] after edge N.
  - Inputs must be single-cycle pulses. A level held high re-requests on every cycle.
- Overrun:
  - overrun[i] is set when edge_pulse[i]=1 while pending[i]=1 and source i is not being accepted in that cycle.
  - overrun_clear clears all bits at the next edge; a simultaneous set on bit i wins for bit i.
- Accept collision: edge_pulse[i]=1 in the same cycle that source i is accepted leaves pending[i]=1. This is a new event, not an overrun.
- FSM states IDLE, OFFER, HOLD:
  - IDLE:
    - If any pending bit is set, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., width-1, 0, ...).
    - Register event_id and event_valid=1, then go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - event_valid and event_id are held unchanged until event_valid & event_ready at an edge.
    - On accept: clear pending[event_id], set rr_ptr = (event_id+1) mod width, set event_valid=0.
    - Then go to HOLD with counter=GAP-1 if GAP>0, else go to IDLE.
    - New pulses never change the offered event_id.
  - HOLD: decrement the counter each cycle; at counter==0 go to IDLE. event_valid stays 0.
- Latency:
  - Pulse sampled at edge N with IDLE and nothing pending: event_valid is high after edge N+1.
  - Accept at edge M: the next event_valid is high no earlier than after edge M+GAP+1.
  - With event_ready tied high, consecutive accepts are GAP+2 edges apart.
- Width rules:
  - The gap counter is $clog2(GAP+1) bits, minimum 1.
  - rr_ptr wraps at width, not at 2^ID_W.
  - event_id never exceeds width-1.

Decomposition:
- Shared package: FSM state encoding (IDLE/OFFER/HOLD) and the ID_W/counter-width helper functions, reused by other pacing blocks.
- One sub-module: rr_pick. It is combinational and takes pending and rr_ptr, returning a found flag and an index.
- FSM, pending/overrun registers and the gap counter stay in the top level.

Test Plan:
1. Reset: assert rst_n=0 mid-OFFER with event_valid=1. Required: event_valid, event_id, overrun and busy go to 0 immediately, without waiting for a clock edge. After release and no pulses, event_valid stays 0 for 20 cycles.
2. Single pulse: width=4, GAP=3, event_ready=1, pulse on source 2 at edge N. Required: event_valid=1 and event_id=2 after edge N+1, for exactly one cycle. busy=0 after edge N+2+3.
3. Simultaneous pulses on sources 0, 1 and 3 (GAP=3, event_ready=1). Required: events 0, 1, 3 in that order, with accepts 5 edges apart.
4. Wrap-around: after source 3 is accepted (rr_ptr=0), pulse sources 3 and 0 together. Required: source 0 is granted first, then source 3.
5. Backpressure and overrun: event_ready=0 for 20 cycles while event_id=1 is offered, and a second pulse arrives on source 1. Required:
   - event_valid and event_id are stable throughout.
   - overrun=4'b0010.
   - overrun_clear=1 for one cycle gives overrun=0 at the next edge.
   - Raising event_ready then delivers exactly one event for source 1.
6. Accept collision: pulse on source 2 in the same cycle that source 2 is accepted. Required: overrun stays 0, and a second event_id=2 is offered after the GAP.

Source files
------------

// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for pacing/arbitration blocks: FSM state encoding and
// width helpers for event indices and hold-off counters.
package button_event_arbiter_pkg;

    // Offer FSM: wait for work, present one event, then pace the consumer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Bits needed to index n sources (never less than 1).
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to count down from gap-1 to 0 (never less than 1).
    function automatic int cnt_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Round-robin search: first set bit of pending_i at or above ptr_i, wrapping
// at WIDTH (not at 2^ID_W), so the returned index is always below WIDTH.
module button_event_arbiter_rr_pick #(
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic [WIDTH-1:0] pending_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [ID_W-1:0]  idx_o
);

    // Walk the sources in priority order starting at the pointer; first hit wins.
    always_comb begin
        int j;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < WIDTH; k++) begin
            j = int'(ptr_i) + k;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!found_o && pending_i[j[ID_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Shares one event consumer among `width` edge-detected pulse sources.
// Pulses are latched as pending requests, offered round-robin, and each
// accepted event is followed by GAP idle cycles. Lost pulses set a sticky
// per-source overrun flag.
//
// Handshake: event_valid/event_id are registered and held unchanged while
// event_valid=1; an event transfers on a clock edge where event_valid and
// event_ready are both 1. event_valid never depends combinationally on
// event_ready.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter  int width = 4,
    parameter  int GAP   = 10,
    localparam int ID_W  = id_width(width)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [width-1:0]  edge_pulse,
    output logic              event_valid,
    input  logic              event_ready,
    output logic [ID_W-1:0]   event_id,
    output logic [width-1:0]  overrun,
    input  logic              overrun_clear,
    output logic              busy
);

    localparam int            CW       = cnt_width(GAP);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);

    state_e             state_q, state_d;
    logic [width-1:0]   pending_q, pending_d;
    logic [width-1:0]   overrun_q, overrun_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               valid_q, valid_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               accept;
    logic [width-1:0]   accept_mask;

    button_event_arbiter_rr_pick #(
        .WIDTH (width),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    // The offered event transfers this cycle; valid_q is 1 whenever in OFFER.
    assign accept      = (state_q == ST_OFFER) && event_ready;
    assign accept_mask = accept ? ({{(width-1){1'b0}}, 1'b1} << id_q) : '0;

    // Pending/overrun update: a pulse on the source being accepted re-arms it
    // (new event); a pulse on any other already-pending source is lost.
    always_comb begin
        pending_d = (pending_q & ~accept_mask) | edge_pulse;
        overrun_d = (overrun_clear ? '0 : overrun_q)
                  | (edge_pulse & pending_q & ~accept_mask);
    end

    // Offer FSM next-state and registered outputs.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    id_d    = pick_idx;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (event_ready) begin
                    valid_d  = 1'b0;
                    rr_ptr_d = (id_q == ID_W'(width - 1)) ? '0 : id_q + ID_W'(1);
                    if (GAP > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset takes effect immediately, even mid-handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign event_valid = valid_q;
    assign event_id    = id_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter (width=4, GAP=3): directed scenarios plus
// random traffic, checked against an event-level reference model.
module tb_button_event_arbiter;

    localparam int W   = 4;
    localparam int G   = 3;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   edge_pulse;
    logic           event_valid;
    logic           event_ready;
    logic [IDW-1:0] event_id;
    logic [W-1:0]   overrun;
    logic           overrun_clear;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [IDW-1:0] exp_q[$];

    button_event_arbiter #(.width(W), .GAP(G)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .edge_pulse    (edge_pulse),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_id      (event_id),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .busy          (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    bit m_pend[W];
    bit m_ovr[W];
    bit m_valid;
    int m_id, m_ptr, m_gap;
    bit acc, found;
    bit old_pend[W];
    int jj;

    function automatic int m_ovr_val();
        int v = 0;
        for (int i = 0; i < W; i++) if (m_ovr[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int m_busy();
        int b = (m_valid || m_gap > 0) ? 1 : 0;
        for (int i = 0; i < W; i++) if (m_pend[i]) b = 1;
        return b;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                m_pend[i] = 0;
                m_ovr[i]  = 0;
            end
            m_valid = 0; m_id = 0; m_ptr = 0; m_gap = 0;
            exp_q.delete();
        end else begin
            acc = m_valid && (event_ready === 1'b1);
            for (int i = 0; i < W; i++) old_pend[i] = m_pend[i];
            for (int i = 0; i < W; i++) begin
                if (edge_pulse[i] && m_pend[i] && !(acc && m_id == i)) m_ovr[i] = 1;
                else if (overrun_clear) m_ovr[i] = 0;
                if (acc && m_id == i) m_pend[i] = 0;
                if (edge_pulse[i]) m_pend[i] = 1;
            end
            if (m_valid) begin
                if (acc) begin
                    m_valid = 0;
                    m_ptr   = (m_id + 1) % W;
                    m_gap   = G;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                found = 0;
                for (int k = 0; k < W; k++) begin
                    jj = (m_ptr + k) % W;
                    if (!found && old_pend[jj]) begin
                        found = 1;
                        m_id  = jj;
                    end
                end
                if (found) begin
                    m_valid = 1;
                    exp_q.push_back(IDW'(m_id));
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("valid", event_valid, m_valid);
            if (m_valid && event_valid) check("id_stable", event_id, m_id);
            check("overrun", overrun, m_ovr_val());
            check("busy", busy, m_busy());
            if (event_valid === 1'b1 && event_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    check("event_id", event_id, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [W-1:0] p, input logic r, input logic clr);
        edge_pulse    = p;
        event_ready   = r;
        overrun_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step('0, r, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; edge_pulse = '0; event_ready = 1'b0; overrun_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", event_valid, 0);
        check("rst_id", event_id, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Asynchronous reset in the middle of an offer with an overrun pending.
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        check("pre_rst_valid", event_valid, 1);
        check("pre_rst_overrun", overrun, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", event_valid, 0);
        check("async_id", event_id, 0);
        check("async_overrun", overrun, 0);
        check("async_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        edge_pulse = '0; event_ready = 1'b0; overrun_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step('0, 1'b0, 1'b0);
            check("post_rst_quiet", event_valid, 0);
        end

        // Single pulse on source 2 with consumer always ready.
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("single_valid", event_valid, 1);
        check("single_id", event_id, 2);
        step(4'b0000, 1'b1, 1'b0);
        check("single_one_cycle", event_valid, 0);
        idle(3, 1'b1);
        check("single_busy_clear", busy, 0);
        idle(5, 1'b1);

        // Simultaneous pulses on 0, 1, 3: served 0, 1, 3 (ends with rr_ptr=0).
        step(4'b1011, 1'b1, 1'b0);
        idle(20, 1'b1);

        // Wrap-around: 3 and 0 together with rr_ptr=0 -> 0 first, then 3.
        step(4'b1001, 1'b1, 1'b0);
        idle(20, 1'b1);

        // Backpressure with a lost pulse on source 1, then clear and drain.
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(17, 1'b0);
        check("bp_valid", event_valid, 1);
        check("bp_id", event_id, 1);
        check("bp_overrun", overrun, 4'b0010);
        step(4'b0000, 1'b0, 1'b1);
        check("ovr_clear", overrun, 0);
        idle(12, 1'b1);

        // Accept collision on source 2: re-armed, no overrun.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        check("collision_overrun", overrun, 0);
        idle(20, 1'b1);

        // Random traffic with backpressure and occasional clears.
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] p;
            for (int b = 0; b < W; b++) p[b] = ($urandom_range(0, 7) == 0);
            step(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        idle(40, 1'b1);
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
